// File: rtl/i2c_bit_engine.sv
// Byte-level I2C master: START/WRITE/READ/STOP commands -> open-drain SCL/SDA enables.
// Optional SCL clock stretching is enabled by defining I2C_CLK_STRETCH_EN.
module i2c_bit_engine #(
  parameter int unsigned CLK_DIV     = 125,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk50,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  input  logic       cmd_nack_last,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_nack,
  output logic       busy,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_i,
  input  logic       sda_i
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_STOP, S_DONE} state_t;
  typedef enum logic [1:0] {OP_START = 2'b00, OP_WRITE = 2'b01, OP_READ = 2'b10, OP_STOP = 2'b11} op_t;

  localparam logic [15:0] CNT_MAX = 16'(CLK_DIV - 1);

  state_t                 state_q, state_d;
  op_t                    op_q, op_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [1:0]             phase_q, phase_d;
  logic [3:0]             bit_q, bit_d;
  logic [7:0]             sh_q, sh_d;
  logic                   nack_last_q, nack_last_d;
  logic                   ack_q, ack_d;
  logic                   ready_q, ready_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [7:0]             rsp_data_q, rsp_data_d;
  logic                   rsp_nack_q, rsp_nack_d;
  logic                   busy_q, busy_d;
  logic                   scl_oe_q, scl_oe_d;
  logic                   sda_oe_q, sda_oe_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   sda_s;
  logic                   tick;
  logic                   hold;

`ifdef I2C_CLK_STRETCH_EN
  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
`else
  logic unused_scl;
  assign unused_scl = scl_i;
`endif

  assign sda_s = sda_sync_q[SYNC_STAGES-1];
  assign tick  = (cnt_q == CNT_MAX);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    phase_d     = phase_q;
    bit_d       = bit_q;
    sh_d        = sh_q;
    nack_last_d = nack_last_q;
    ack_d       = ack_q;
    ready_d     = ready_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_nack_d  = rsp_nack_q;
    busy_d      = busy_q;
    scl_oe_d    = scl_oe_q;
    sda_oe_d    = sda_oe_q;
    sda_sync_d  = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
`ifdef I2C_CLK_STRETCH_EN
    scl_sync_d  = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
    // A slave holding SCL low freezes the counter at the start of p1.
    hold        = (phase_q == 2'd1) && (cnt_q == '0) && !scl_sync_q[SYNC_STAGES-1];
`else
    hold        = 1'b0;
`endif

    if (state_q == S_START || state_q == S_BIT || state_q == S_STOP) begin
      cnt_d = tick ? '0 : (hold ? cnt_q : cnt_q + 16'd1);
      if (tick) phase_d = phase_q + 2'd1;
    end

    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (cmd_valid && ready_q) begin
          ready_d     = 1'b0;
          op_d        = op_t'(cmd_op);
          sh_d        = cmd_data;
          nack_last_d = cmd_nack_last;
          cnt_d       = '0;
          phase_d     = '0;
          bit_d       = '0;
          case (op_t'(cmd_op))
            OP_START: state_d = S_START;
            OP_STOP:  state_d = S_STOP;
            default:  state_d = S_BIT;
          endcase
        end
      end
      S_START: begin
        case (phase_q)
          2'd0: sda_oe_d = 1'b0;
          2'd1: scl_oe_d = 1'b0;
          2'd2: sda_oe_d = 1'b1;
          default: begin
            scl_oe_d = 1'b1;
            if (tick) state_d = S_DONE;
          end
        endcase
      end
      S_BIT: begin
        case (phase_q)
          2'd0: begin
            scl_oe_d = 1'b1;
            if (bit_q == 4'd8) sda_oe_d = (op_q == OP_READ) ? ~nack_last_q : 1'b0;
            else               sda_oe_d = (op_q == OP_WRITE) ? ~sh_q[7] : 1'b0;
          end
          2'd1: scl_oe_d = 1'b0;
          2'd2: begin
            scl_oe_d = 1'b0;
            if (tick) begin
              if (bit_q == 4'd8)      ack_d = sda_s;
              else if (op_q == OP_READ) sh_d = {sh_q[6:0], sda_s};
            end
          end
          default: begin
            scl_oe_d = 1'b1;
            if (tick) begin
              bit_d = bit_q + 4'd1;
              if (op_q == OP_WRITE && bit_q != 4'd8) sh_d = {sh_q[6:0], 1'b0};
              if (bit_q == 4'd8) state_d = S_DONE;
            end
          end
        endcase
      end
      S_STOP: begin
        case (phase_q)
          2'd0: begin
            scl_oe_d = 1'b1;
            sda_oe_d = 1'b1;
          end
          2'd1: scl_oe_d = 1'b0;
          2'd2: sda_oe_d = 1'b0;
          default: if (tick) state_d = S_DONE;
        endcase
      end
      S_DONE: begin
        rsp_valid_d = 1'b1;
        ready_d     = 1'b1;
        rsp_data_d  = (op_q == OP_READ) ? sh_q : '0;
        rsp_nack_d  = (op_q == OP_WRITE) ? ack_q : 1'b0;
        if (op_q == OP_START) busy_d = 1'b1;
        if (op_q == OP_STOP)  busy_d = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= OP_START;
      cnt_q       <= '0;
      phase_q     <= '0;
      bit_q       <= '0;
      sh_q        <= '0;
      nack_last_q <= 1'b0;
      ack_q       <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_nack_q  <= 1'b0;
      busy_q      <= 1'b0;
      scl_oe_q    <= 1'b0;
      sda_oe_q    <= 1'b0;
      sda_sync_q  <= '1;
`ifdef I2C_CLK_STRETCH_EN
      scl_sync_q  <= '1;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      bit_q       <= bit_d;
      sh_q        <= sh_d;
      nack_last_q <= nack_last_d;
      ack_q       <= ack_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_nack_q  <= rsp_nack_d;
      busy_q      <= busy_d;
      scl_oe_q    <= scl_oe_d;
      sda_oe_q    <= sda_oe_d;
      sda_sync_q  <= sda_sync_d;
`ifdef I2C_CLK_STRETCH_EN
      scl_sync_q  <= scl_sync_d;
`endif
    end
  end

  assign cmd_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_nack  = rsp_nack_q;
  assign busy      = busy_q;
  assign scl_oe    = scl_oe_q;
  assign sda_oe    = sda_oe_q;

endmodule

// File: tb/tb_i2c_bit_engine.sv
// Directed/randomized bench for i2c_bit_engine with an open-drain bus and a behavioural slave.
module tb_i2c_bit_engine;
  localparam int unsigned D = 4;
  localparam int NOM_BYTE = 36 * D + 1;
  localparam int NOM_SS   = 4 * D + 1;
  localparam int M_NONE = 0, M_ACK = 1, M_NACK = 2, M_READ = 3;

  logic       clk50 = 1'b0;
  logic       rst_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_nack_last = 1'b0;
  logic       cmd_ready, rsp_valid, rsp_nack, busy, scl_oe, sda_oe;
  logic [7:0] rsp_data;
  logic       slv_scl_low = 1'b0;
  logic       slv_sda_low;
  logic       scl_pin, sda_pin;

  int vectors = 0, miscompares = 0;
  int cyc = 0, oe_cnt = 0, rise_cnt = 0, starts = 0, stops = 0;
  int t0 = 0, oe0 = 0, cmd_base = 0;
  logic sda_at_rise[$];
  logic oe_at_rise[$];

  int         slv_mode = 0;
  logic [7:0] slv_byte = 8'h00;
  int         slv_base = 0;
  int         slv_idx;

  i2c_bit_engine #(.CLK_DIV(D), .SYNC_STAGES(2)) dut (
    .clk50(clk50), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_nack_last(cmd_nack_last),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_nack(rsp_nack), .busy(busy),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .scl_i(scl_pin), .sda_i(sda_pin)
  );

  assign scl_pin = ~(scl_oe | slv_scl_low);
  assign sda_pin = ~(sda_oe | slv_sda_low);

  always #5 clk50 = ~clk50;
  always @(posedge clk50) cyc <= cyc + 1;
  always @(posedge clk50) if (sda_oe) oe_cnt <= oe_cnt + 1;

  always @(posedge scl_pin) begin
    sda_at_rise.push_back(sda_pin);
    oe_at_rise.push_back(sda_oe);
    rise_cnt = rise_cnt + 1;
  end
  always @(negedge sda_pin) if (scl_pin) starts = starts + 1;
  always @(posedge sda_pin) if (scl_pin) stops = stops + 1;

  // Slave only updates what it drives while SCL is low.
  always_latch if (!scl_pin) slv_idx <= rise_cnt - slv_base;

  function automatic logic slv_drive(input int mode, input logic [7:0] b, input int idx);
    logic [7:0] sh;
    sh = b << idx;
    if (mode == M_READ && idx >= 0 && idx < 8) return ~sh[7];
    if (mode == M_ACK && idx == 8) return 1'b1;
    return 1'b0;
  endfunction
  assign slv_sda_low = slv_drive(slv_mode, slv_byte, slv_idx);

  function automatic logic [7:0] seen_byte(input int base);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < 8; i++) b = {b[6:0], sda_at_rise[base + i]};
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_lat(input string tag, input int lat, input int nom, input int extra);
`ifdef I2C_CLK_STRETCH_EN
    chk(tag, 32'(lat >= nom + extra && lat <= nom + extra + 72), 32'd1);
`else
    chk(tag, 32'(lat), 32'(nom + extra));
`endif
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] d, input logic nl,
                       input int mode, input logic [7:0] sb);
    int n;
    @(negedge clk50);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_nack_last = nl;
    n = 0;
    while (!cmd_ready && n < 2000) begin @(negedge clk50); n++; end
    chk("accept_wait", 32'(n < 2000), 32'd1);
    slv_mode = mode; slv_byte = sb; slv_base = rise_cnt; cmd_base = rise_cnt;
    @(negedge clk50);
    t0 = cyc; oe0 = oe_cnt; cmd_valid = 1'b0;
    chk("ready_drop", 32'(cmd_ready), 32'd0);
  endtask

  task automatic finish_cmd(input logic [7:0] exp_d, input logic exp_n, input int nom,
                            input int extra, input string tag);
    int n, lat;
    n = 0;
    while (!rsp_valid && n < 5000) begin @(negedge clk50); n++; end
    chk({tag, "_rsp_seen"}, 32'(rsp_valid), 32'd1);
    lat = cyc - t0;
    chk_lat({tag, "_latency"}, lat, nom, extra);
    chk({tag, "_rsp_data"}, 32'(rsp_data), 32'(exp_d));
    chk({tag, "_rsp_nack"}, 32'(rsp_nack), 32'(exp_n));
    chk({tag, "_ready_at_rsp"}, 32'(cmd_ready), 32'd1);
    @(negedge clk50);
    chk({tag, "_rsp_pulse"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_hold"}, 32'({rsp_nack, rsp_data}), 32'({exp_n, exp_d}));
  endtask

  task automatic run(input logic [1:0] op, input logic [7:0] d, input logic nl, input int mode,
                     input logic [7:0] sb, input logic [7:0] exp_d, input logic exp_n,
                     input int nom, input string tag);
    issue(op, d, nl, mode, sb);
    finish_cmd(exp_d, exp_n, nom, 0, tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, observed hang expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    logic       ackit;
    int         s0, n;

    #1 rst_n = 1'b0;
    #20;
    chk("reset_outputs", 32'({cmd_ready, rsp_valid, busy, scl_oe, sda_oe, rsp_nack, rsp_data}), 32'd0);
    @(negedge clk50) rst_n = 1'b1;
    @(negedge clk50);
    chk("ready_after_reset", 32'(cmd_ready), 32'd1);

    s0 = starts;
    run(2'b00, 8'h00, 1'b0, M_NONE, 8'h00, 8'h00, 1'b0, NOM_SS, "start");
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_seen", 32'(starts - s0), 32'd1);
    chk("start_scl_low", 32'(scl_oe), 32'd1);

    run(2'b01, 8'hA5, 1'b0, M_ACK, 8'h00, 8'h00, 1'b0, NOM_BYTE, "wr_a5");
    chk("wr_a5_bits", 32'(seen_byte(cmd_base)), 32'h0A5);
    chk("wr_a5_busy", 32'(busy), 32'd1);

    run(2'b01, 8'h3A, 1'b0, M_NACK, 8'h00, 8'h00, 1'b1, NOM_BYTE, "wr_3a");
    chk("wr_3a_bits", 32'(seen_byte(cmd_base)), 32'h03A);

    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      ackit = 1'($urandom_range(0, 1));
      run(2'b01, b, 1'b0, ackit ? M_ACK : M_NACK, 8'h00, 8'h00, ~ackit, NOM_BYTE, "wr_rand");
      chk("wr_rand_bits", 32'(seen_byte(cmd_base)), 32'(b));
    end

    issue(2'b10, 8'h00, 1'b1, M_READ, 8'h3C);
    finish_cmd(8'h3C, 1'b0, NOM_BYTE, 0, "rd_3c");
    chk("rd_nack_oe_window", 32'(oe_cnt - oe0), 32'd0);
    chk("rd_nack_sda_bit", 32'(sda_at_rise[cmd_base + 8]), 32'd1);

    b = 8'($urandom);
    issue(2'b10, 8'h00, 1'b0, M_READ, b);
    finish_cmd(b, 1'b0, NOM_BYTE, 0, "rd_ack");
    n = 0;
    for (int i = 0; i < 8; i++) n += int'(oe_at_rise[cmd_base + i]);
    chk("rd_ack_data_oe", 32'(n), 32'd0);
    chk("rd_ack_oe_bit", 32'(oe_at_rise[cmd_base + 8]), 32'd1);
    chk("rd_ack_sda_bit", 32'(sda_at_rise[cmd_base + 8]), 32'd0);
    chk("rd_ack_oe_end", 32'(sda_oe), 32'd1);

    s0 = starts;
    run(2'b00, 8'h00, 1'b0, M_NONE, 8'h00, 8'h00, 1'b0, NOM_SS, "rstart");
    chk("rstart_seen", 32'(starts - s0), 32'd1);

    b = 8'($urandom);
    run(2'b01, b, 1'b0, M_ACK, 8'h00, 8'h00, 1'b0, NOM_BYTE, "wr_pre_stop");
    chk("wr_pre_stop_bits", 32'(seen_byte(cmd_base)), 32'(b));
    s0 = stops;
    run(2'b11, 8'h00, 1'b0, M_NONE, 8'h00, 8'h00, 1'b0, NOM_SS, "stop");
    chk("stop_seen", 32'(stops - s0), 32'd1);
    chk("stop_bus_free", 32'({busy, scl_oe, sda_oe}), 32'd0);

    run(2'b00, 8'h00, 1'b0, M_NONE, 8'h00, 8'h00, 1'b0, NOM_SS, "start2");
    issue(2'b01, 8'($urandom), 1'b0, M_ACK, 8'h00);
    n = 0;
    while (rise_cnt - cmd_base < 4 && n < 1000) begin @(negedge clk50); n++; end
    chk("reset_mid_reach_bit4", 32'(n < 1000), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_mid_release", 32'({scl_oe, sda_oe, cmd_ready, busy, rsp_valid}), 32'd0);
    repeat (3) @(negedge clk50);
    chk("reset_mid_ready_low", 32'(cmd_ready), 32'd0);
    rst_n = 1'b1;
    slv_mode = M_NONE;

    run(2'b00, 8'h00, 1'b0, M_NONE, 8'h00, 8'h00, 1'b0, NOM_SS, "start3");
    b = 8'($urandom);
    run(2'b01, b, 1'b0, M_ACK, 8'h00, 8'h00, 1'b0, NOM_BYTE, "wr_after_rst");
    chk("wr_after_rst_bits", 32'(seen_byte(cmd_base)), 32'(b));

`ifdef I2C_CLK_STRETCH_EN
    b = 8'($urandom);
    issue(2'b01, b, 1'b0, M_ACK, 8'h00);
    n = 0;
    while (!(rise_cnt - cmd_base >= 3 && !scl_pin) && n < 1000) begin @(negedge clk50); n++; end
    slv_scl_low = 1'b1;
    while (scl_oe && n < 2000) begin @(negedge clk50); n++; end
    chk("stretch_reach_bit3", 32'(n < 2000), 32'd1);
    repeat (20) @(negedge clk50);
    slv_scl_low = 1'b0;
    finish_cmd(8'h00, 1'b0, NOM_BYTE, 20, "wr_stretch");
    chk("wr_stretch_bits", 32'(seen_byte(cmd_base)), 32'(b));
`endif

    run(2'b11, 8'h00, 1'b0, M_NONE, 8'h00, 8'h00, 1'b0, NOM_SS, "stop2");
    chk("stop2_bus_free", 32'({busy, scl_oe, sda_oe}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
